// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - fixed-latency data-memory responder with sized, sign/zero-extended loads
// Stalls the CPU through BUSYWAIT for LATENCY+1 cycles per request, then completes the access.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      read_data_q, read_data_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             req;
    logic             busy;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;
    logic             load_ok;
    logic [31:0]      wdata_lane;
    logic [3:0]       byte_en;
    logic             store_ok;
    logic             access;
    logic             mem_we;
    logic             unused_addr;

    // Upper address bits are ignored so accesses wrap modulo DEPTH_WORDS.
    assign word_idx    = ADDR[2 +: IDX_W];
    assign unused_addr = ^ADDR;
    assign req         = READ[3] | WRITE[2];
    assign rd_word     = mem[word_idx];
    assign byte_sel    = rd_word[{ADDR[1:0], 3'b000} +: 8];
    assign half_sel    = rd_word[{ADDR[1], 4'b0000} +: 16];

    always_comb begin
        load_val = 32'h0;
        load_ok  = 1'b1;
        case (READ[2:0])
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_ok  = 1'b0;
        endcase
    end

    // Store data is replicated across lanes; byte_en picks which lanes land.
    always_comb begin
        wdata_lane = WRITE_DATA;
        byte_en    = 4'b0000;
        store_ok   = 1'b1;
        case (WRITE[1:0])
            2'b00: begin
                wdata_lane = {4{WRITE_DATA[7:0]}};
                byte_en    = 4'b0001 << ADDR[1:0];
            end
            2'b01: begin
                wdata_lane = {2{WRITE_DATA[15:0]}};
                byte_en    = ADDR[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: byte_en = 4'b1111;
            default: store_ok = 1'b0;
        endcase
    end

    assign access = (state_q == S_BUSY) && (cnt_q == '0);
    assign mem_we = access && WRITE[2] && store_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        busy        = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = req;
                if (req) begin
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (WRITE[2]) begin
                        if (READ[3]) begin
                            read_data_d = 32'h0;
                        end
                    end else if (READ[3]) begin
                        read_data_d = load_ok ? load_val : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // The request is still present here; returning to IDLE without looking
            // at it keeps the completed access from being issued a second time.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    assign READ_DATA = read_data_q;
    assign BUSYWAIT  = busy & RST;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed self-checking bench for data_memory_responder
// Drives inputs on the falling edge and samples 1 ns later.
module tb_data_memory_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] rdata;
    logic        busywait;

    int n_assert;
    int n_fail;
    logic [31:0] held;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK(clk),
        .RST(rst_n),
        .ADDR(addr),
        .WRITE_DATA(wdata),
        .READ(rd),
        .WRITE(wr),
        .READ_DATA(rdata),
        .BUSYWAIT(busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: counts busy cycles, checks READ_DATA holds while busy and
    // carries exp in the DONE cycle. Returns while sampling the DONE cycle.
    task automatic access(input string tag, input logic [3:0] r, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        int   n;
        logic held_ok;
        @(negedge clk);
        addr = a; wdata = d; rd = r; wr = w;
        #1;
        n = 0;
        held_ok = 1'b1;
        while (busywait === 1'b1 && n < 10) begin
            if (rdata !== held) held_ok = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(LAT + 1));
        check({tag, "_held_while_busy"}, {31'h0, held_ok}, 32'h1);
        check({tag, "_data"}, rdata, exp);
        held = exp;
    endtask

    task automatic idle();
        @(negedge clk);
        rd = 4'h0; wr = 3'h0;
        #1;
        check("idle_busywait", {31'h0, busywait}, 32'h0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        held     = 32'h0;
        rst_n = 1'b0; addr = 32'h0; wdata = 32'h0; rd = 4'h0; wr = 3'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_read_data", rdata, 32'h0);
        check("reset_busywait", {31'h0, busywait}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle_no_request", {31'h0, busywait}, 32'h0);

        // Test 1: SW then LW
        access("sw_10", 4'h0, 3'b110, 32'h10, 32'hDEADBEEF, held);
        idle();
        access("lw_10", 4'b1010, 3'h0, 32'h10, 32'h0, 32'hDEADBEEF);
        idle();
        check("read_data_holds_idle", rdata, 32'hDEADBEEF);

        // Test 2: SB and byte loads
        access("sw_20", 4'h0, 3'b110, 32'h20, 32'h44332211, held);
        access("sb_21", 4'h0, 3'b100, 32'h21, 32'hFFFFFF80, held);
        access("lb_21", 4'b1000, 3'h0, 32'h21, 32'h0, 32'hFFFFFF80);
        access("lbu_21", 4'b1100, 3'h0, 32'h21, 32'h0, 32'h00000080);
        access("lw_20", 4'b1010, 3'h0, 32'h20, 32'h0, 32'h44338011);
        access("lbu_23", 4'b1100, 3'h0, 32'h23, 32'h0, 32'h00000044);
        idle();

        // Test 3: SH and half loads
        access("sw_30", 4'h0, 3'b110, 32'h30, 32'hAABBCCDD, held);
        access("sh_32", 4'h0, 3'b101, 32'h32, 32'h12348001, held);
        access("lh_32", 4'b1001, 3'h0, 32'h32, 32'h0, 32'hFFFF8001);
        access("lhu_32", 4'b1101, 3'h0, 32'h32, 32'h0, 32'h00008001);
        access("lh_33", 4'b1001, 3'h0, 32'h33, 32'h0, 32'hFFFF8001);
        access("lw_30", 4'b1010, 3'h0, 32'h30, 32'h0, 32'h8001CCDD);
        access("lb_30", 4'b1000, 3'h0, 32'h30, 32'h0, 32'hFFFFFFDD);
        access("lhu_30", 4'b1101, 3'h0, 32'h30, 32'h0, 32'h0000CCDD);
        idle();

        // Test 4: back-to-back loads, request held through DONE
        access("sw_14", 4'h0, 3'b110, 32'h14, 32'h11223344, held);
        idle();
        access("b2b_lw_10", 4'b1010, 3'h0, 32'h10, 32'h0, 32'hDEADBEEF);
        access("b2b_lw_14", 4'b1010, 3'h0, 32'h14, 32'h0, 32'h11223344);
        idle();

        // Test 5: reset during a store
        access("sw_40", 4'h0, 3'b110, 32'h40, 32'h0BADF00D, held);
        access("lw_40_pre", 4'b1010, 3'h0, 32'h40, 32'h0, 32'h0BADF00D);
        idle();
        @(negedge clk);
        addr = 32'h40; wdata = 32'h12345678; rd = 4'h0; wr = 3'b110;
        #1;
        check("rst_busy_start", {31'h0, busywait}, 32'h1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busywait", {31'h0, busywait}, 32'h0);
        check("rst_read_data", rdata, 32'h0);
        held = 32'h0;
        rd = 4'h0; wr = 3'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();
        access("lw_40_post", 4'b1010, 3'h0, 32'h40, 32'h0, 32'h0BADF00D);
        idle();

        // Test 6: wrap-around and undefined codes
        access("lw_wrap", 4'b1010, 3'h0, 32'(DEPTH * 4 + 32'h10), 32'h0, 32'hDEADBEEF);
        access("rd_undef", 4'b1011, 3'h0, 32'h10, 32'h0, 32'h0);
        access("lw_10_again", 4'b1010, 3'h0, 32'h10, 32'h0, 32'hDEADBEEF);
        access("rd_wr_both", 4'b1010, 3'b110, 32'h50, 32'h55667788, 32'h0);
        access("lw_50", 4'b1010, 3'h0, 32'h50, 32'h0, 32'h55667788);
        access("wr_undef", 4'h0, 3'b111, 32'h50, 32'h0, held);
        access("lw_50_kept", 4'b1010, 3'h0, 32'h50, 32'h0, 32'h55667788);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
